// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    // Access-type encoding carried on the request funct3 field
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Latency counter width; holds LATENCY-1 for LATENCY up to 15
    localparam int unsigned CntW = 4;

    function automatic logic is_legal_f3(logic [2:0] funct3);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables and replicated store data, and
// lane selection plus sign/zero extension for loads.
module load_store_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wbe_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] lane;

    // Decode funct3 into enables and extended read data
    always_comb begin
        wbe_o   = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
        // Addressed byte moved down to bit 0
        lane    = rword_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_B: begin
                wbe_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{lane[7]}}, lane[7:0]};
            end
            F3_BU: begin
                wbe_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, lane[7:0]};
            end
            F3_H: begin
                wbe_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{lane[15]}}, lane[15:0]};
            end
            F3_HU: begin
                wbe_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, lane[15:0]};
            end
            F3_W: begin
                wbe_o   = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// valid/ready on both request and response sides.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] idx_q;
    logic [1:0]      lo_q;
    logic [2:0]      f3_q;
    logic            write_q;
    logic            err_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [IdxW-1:0] req_idx;
    logic            req_err;
    logic            store_en;
    logic [2:0]      al_f3;
    logic [1:0]      al_lo;
    logic [3:0]      al_wbe;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rdata;

    assign req_idx  = req_addr_i[IdxW+1:2];
    assign req_err  = !is_legal_f3(req_funct3_i) || is_misaligned(req_funct3_i, req_addr_i[1:0]);
    assign store_en = (state_q == StIdle) && req_valid_i && req_write_i && !req_err;

    // One aligner serves both paths: stores only commit in IDLE, loads only
    // complete from WAIT, so steer it with live or captured fields by state.
    assign al_f3 = (state_q == StIdle) ? req_funct3_i   : f3_q;
    assign al_lo = (state_q == StIdle) ? req_addr_i[1:0] : lo_q;

    load_store_align u_align (
        .funct3_i  (al_f3),
        .addr_lo_i (al_lo),
        .wdata_i   (req_wdata_i),
        .rword_i   (mem_q[idx_q]),
        .wbe_o     (al_wbe),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    // Byte-enabled store into the array on the acceptance edge; array is not reset
    always_ff @(posedge clk) begin
        if (!rst && store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (al_wbe[b]) begin
                    mem_q[req_idx][8*b +: 8] <= al_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with latency counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            f3_q        <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        idx_q       <= req_idx;
                        lo_q        <= req_addr_i[1:0];
                        f3_q        <= req_funct3_i;
                        write_q     <= req_write_i;
                        err_q       <= req_err;
                        cnt_q       <= CntInit;
                        req_ready_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (err_q || write_q) ? 32'h0 : al_rdata;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=2 instance for function,
// latency, backpressure and reset; LATENCY=1 instance for throughput.
module tb_data_mem_responder;

    localparam int unsigned Lat = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = 3'b010;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic        rsp_valid1;
    logic [31:0] rsp_rdata1;
    logic        rsp_err1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (Lat)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_funct3_i (req_funct3),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (1)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid1),
        .req_ready_o  (req_ready1),
        .req_write_i  (1'b0),
        .req_addr_i   (32'h0),
        .req_wdata_i  (32'h0),
        .req_funct3_i (3'b010),
        .rsp_valid_o  (rsp_valid1),
        .rsp_ready_i  (1'b1),
        .rsp_rdata_o  (rsp_rdata1),
        .rsp_err_o    (rsp_err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: latency on rise, payload on handshake
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !prev_valid && sb_q.size() > 0)
            check_eq("latency", 32'(cyc - sb_q[0].acc), 32'(Lat));
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic [31:0] er, input logic ee);
        bit ok = 0;
        @(posedge clk); #1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f3;
        req_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                sb_q.push_back('{rdata: er, err: ee, acc: cyc + 1});
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check_eq("rsp_timeout", 32'(sb_q.size()), 32'h0);
            sb_q.delete();
        end
    endtask

    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee);
        issue(w, a, d, f3, er, ee);
        wait_done();
    endtask

    initial begin
        int acc_c[$];
        bit seen;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Word round trip and extensions
        op(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        op(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
        op(1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
        op(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0);
        op(1'b0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);

        // Partial store
        op(1'b1, 32'h11, 32'hAAAAAA55, 3'b000, 32'h0, 1'b0);
        op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        // Misaligned and illegal accesses leave the array alone
        op(1'b1, 32'h12, 32'h11111111, 3'b010, 32'h0, 1'b1);
        op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
        op(1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1);
        op(1'b1, 32'h10, 32'h22222222, 3'b011, 32'h0, 1'b1);
        op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        // Backpressure: response held stable while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check_eq("bp_rsp_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(rsp_valid), 32'h1);
            check_eq("bp_rdata", rsp_rdata, 32'hDEAD55EF);
            check_eq("bp_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_done();

        // Reset while in WAIT drops the pending response
        issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("midrst_req_ready", 32'(req_ready), 32'h1);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("midrst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        // Array survives reset
        op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        // Address wrap-around and upper-half store/load
        op(1'b1, 32'h1000, 32'h12345678, 3'b010, 32'h0, 1'b0);
        op(1'b0, 32'h0, 32'h0, 3'b010, 32'h12345678, 1'b0);
        op(1'b1, 32'h2, 32'h0000ABCD, 3'b001, 32'h0, 1'b0);
        op(1'b0, 32'h2, 32'h0, 3'b001, 32'hFFFFABCD, 1'b0);
        op(1'b0, 32'h0, 32'h0, 3'b010, 32'hABCD5678, 1'b0);

        // Back-to-back throughput on the LATENCY=1 instance
        @(posedge clk); #1;
        req_valid1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready1) acc_c.push_back(cyc);
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        check_eq("thru_count", 32'(acc_c.size() >= 4), 32'h1);
        if (acc_c.size() >= 4) begin
            for (int k = 1; k < 4; k++)
                check_eq("thru_interval", 32'(acc_c[k] - acc_c[k-1]), 32'h3);
        end
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
